// File: rtl/disp_pkg.sv
// disp_pkg: shared encodings and sizes for the display mode controller.
package disp_pkg;
  localparam int NUM_DIGITS = 9;
  localparam int DIGIT_W = 4;
  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'd0,
    MODE_STOPWATCH = 2'd1,
    MODE_TIMER     = 2'd2,
    MODE_ALARMSET  = 2'd3
  } mode_e;
  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_ALARM  = 1'b1
  } state_e;
endpackage

// File: rtl/disp_mode_ctrl_blink_timer.sv
// blink_timer: counts frame pulses and toggles blink_phase every BLINK_FRAMES frames.
module blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  output logic blink_phase
);
  localparam int W = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [W-1:0] LAST = W'(BLINK_FRAMES - 1);
  logic [W-1:0] cnt_q, cnt_d;
  logic phase_q, phase_d, wrap;
  always_comb begin
    wrap = cnt_q == LAST;
    cnt_d = !frame_start ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
    phase_d = phase_q ^ (frame_start & wrap);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      phase_q <= phase_d;
    end
  assign blink_phase = phase_q;
endmodule

// File: rtl/disp_mode_ctrl.sv
// disp_mode_ctrl: mode stepping, alarm override and frame-synchronous latching of the
// nine-digit display with per-digit blink masking.
module disp_mode_ctrl
  import disp_pkg::*;
#(
  parameter int BLINK_FRAMES = 30,
  parameter int ALARM_FRAMES = 1800
) (
  input  logic                           CLK,
  input  logic                           RST_BTN,
  input  logic                           frame_start,
  input  logic                           mode_btn,
  input  logic                           alarm_fire,
  input  logic                           edit_en,
  input  logic [3:0]                     edit_sel,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]  clk_digits,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]  sw_digits,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]  tmr_digits,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]  aset_digits,
  output logic [NUM_DIGITS*DIGIT_W-1:0]  disp_digits,
  output logic [NUM_DIGITS-1:0]          disp_blank,
  output logic                           disp_colon,
  output logic [1:0]                     mode,
  output logic                           alarm_active,
  output logic                           update_ack
);
  localparam int AW = ALARM_FRAMES > 1 ? $clog2(ALARM_FRAMES) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_FRAMES - 1);
  localparam logic [NUM_DIGITS-1:0] LEFT_ONE = {1'b1, {(NUM_DIGITS-1){1'b0}}};
  state_e state_q, state_d;
  mode_e mode_q, mode_d;
  logic fire_q, rise, blink_phase, editable;
  logic [AW-1:0] acnt_q, acnt_d;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits_q, digits_d, sel;
  logic [NUM_DIGITS-1:0] blank_q, blank_d, edit_mask;
  logic colon_q, colon_d, ack_q;

  blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk(CLK), .rst_n(RST_BTN), .frame_start(frame_start), .blink_phase(blink_phase)
  );

  assign rise = alarm_fire & ~fire_q;

  always_ff @(posedge CLK or negedge RST_BTN)
    if (!RST_BTN) begin
      state_q <= ST_NORMAL;
      mode_q <= MODE_CLOCK;
      fire_q <= 1'b0;
      acnt_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      fire_q <= alarm_fire;
      acnt_q <= acnt_d;
    end

  // A rising alarm edge wins over a simultaneous button; in ALARM the button only exits.
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    if (state_q == ST_NORMAL) begin
      if (rise) state_d = ST_ALARM;
      else if (mode_btn) mode_d = mode_e'(mode_q + 2'd1);
    end else if (mode_btn || (frame_start && acnt_q == ALARM_LAST)) begin
      state_d = ST_NORMAL;
    end
    acnt_d = state_q == ST_NORMAL ? '0 : frame_start ? acnt_q + 1'b1 : acnt_q;
  end

  // Shifting a left-aligned one by edit_sel leaves nothing for indices past the last digit.
  always_comb begin
    sel = state_q == ST_ALARM      ? clk_digits :
          mode_q == MODE_CLOCK     ? clk_digits :
          mode_q == MODE_STOPWATCH ? sw_digits  :
          mode_q == MODE_TIMER     ? tmr_digits : aset_digits;
    edit_mask = LEFT_ONE >> edit_sel;
    editable = edit_en && (mode_q == MODE_CLOCK || mode_q == MODE_ALARMSET);
    digits_d = frame_start ? sel : digits_q;
    blank_d = !frame_start ? blank_q :
              state_q == ST_ALARM ? {NUM_DIGITS{blink_phase}} :
              (editable && blink_phase) ? edit_mask : '0;
    colon_d = !frame_start ? colon_q : state_q == ST_ALARM ? ~blink_phase : 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_BTN)
    if (!RST_BTN) begin
      digits_q <= '0;
      blank_q <= '0;
      colon_q <= 1'b1;
      ack_q <= 1'b0;
    end else begin
      digits_q <= digits_d;
      blank_q <= blank_d;
      colon_q <= colon_d;
      ack_q <= frame_start;
    end

  assign disp_digits = digits_q;
  assign disp_blank = blank_q;
  assign disp_colon = colon_q;
  assign mode = mode_q;
  assign alarm_active = state_q == ST_ALARM;
  assign update_ack = ack_q;
endmodule
